// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with branch, JALR, trap and return-address-stack redirects
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               hold pc (sequential increment only)
//   br_taken/br_offset  pc-relative branch, signed byte offset
//   jalr_en/jalr_target absolute jump, bit 0 cleared
//   trap                redirect to TRAP_VEC
//   ras_push/ras_pop    call / return on the return-address stack
//   pc, pc_plus4        registered fetch pc and its sequential successor
//   ras_empty           stack holds no entries
//   misalign, ras_ovf, ras_unf  one-cycle event pulses
module pc_gen #(
    parameter int              WIDTH     = 32,
    parameter int              DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(32'h0000_0100)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_offset,
    input  logic             jalr_en,
    input  logic [WIDTH-1:0] jalr_target,
    input  logic             trap,
    input  logic             ras_push,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             ras_empty,
    output logic             misalign,
    output logic             ras_ovf,
    output logic             ras_unf
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] ras [DEPTH];
    logic [AW-1:0]    ptr;
    logic [AW:0]      cnt;
    logic [AW-1:0]    top_idx;
    logic             full, push, pop, pop_hit, jalr_sel, br_sel, mis;
    logic [WIDTH-1:0] target, pc_next;

    // ptr addresses the next free slot, so the top lives one below it
    assign top_idx   = ptr - 1'b1;
    assign pc_plus4  = pc + WIDTH'(4);
    assign ras_empty = cnt == '0;
    assign full      = cnt == (AW+1)'(DEPTH);
    assign push      = ras_push && !trap;
    assign pop       = ras_pop && !trap;
    assign pop_hit   = pop && !ras_empty;

    always_comb begin
        jalr_sel = !trap && !ras_pop && jalr_en;
        br_sel   = !trap && !ras_pop && !jalr_en && br_taken;
        target   = jalr_sel ? (jalr_target & ~WIDTH'(1)) : pc + br_offset;
        mis      = (jalr_sel || br_sel) && (target[1:0] != 2'b00);
        pc_next  = trap                ? TRAP_VEC :
                   ras_pop             ? (ras_empty ? pc_plus4 : ras[top_idx]) :
                   (jalr_sel || br_sel) ? (mis ? TRAP_VEC : target) :
                   stall               ? pc : pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_VEC;
            ptr      <= '0;
            cnt      <= '0;
            misalign <= 1'b0;
            ras_ovf  <= 1'b0;
            ras_unf  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ras[i] <= '0;
        end else begin
            pc       <= pc_next;
            misalign <= mis;
            ras_ovf  <= push && !pop_hit && full;
            ras_unf  <= pop && ras_empty;
            // a combined return+call swaps the top in place; a full push overwrites the oldest slot by wrapping
            if (push && pop_hit) begin
                ras[top_idx] <= pc_plus4;
            end else if (push) begin
                ras[ptr] <= pc_plus4;
                ptr      <= ptr + 1'b1;
                if (!full) cnt <= cnt + 1'b1;
            end else if (pop_hit) begin
                ptr <= ptr - 1'b1;
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst, stall, br_taken, jalr_en, trap, ras_push, ras_pop;
    logic [31:0] br_offset, jalr_target;
    logic [31:0] pc, pc_plus4;
    logic        ras_empty, misalign, ras_ovf, ras_unf;
    int          n_cmp = 0;
    int          n_err = 0;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
        .jalr_en(jalr_en), .jalr_target(jalr_target), .trap(trap), .ras_push(ras_push),
        .ras_pop(ras_pop), .pc(pc), .pc_plus4(pc_plus4), .ras_empty(ras_empty),
        .misalign(misalign), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        {rst, stall, br_taken, jalr_en, trap, ras_push, ras_pop} = '0;
        br_offset = '0;
        jalr_target = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [31:0] t, input logic push);
        jalr_en = 1'b1; jalr_target = t; ras_push = push;
        step();
        idle();
    endtask

    task automatic flags(input string tag, input logic m, input logic o, input logic u, input logic e);
        check({tag, "_mis"}, 32'(misalign), 32'(m));
        check({tag, "_ovf"}, 32'(ras_ovf), 32'(o));
        check({tag, "_unf"}, 32'(ras_unf), 32'(u));
        check({tag, "_empty"}, 32'(ras_empty), 32'(e));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_pc", pc, 32'h0);
        flags("rst", 0, 0, 0, 1);
        step(); check("seq1", pc, 32'h4);
        step(); check("seq2", pc, 32'h8);
        step(); check("seq3", pc, 32'hC);
        check("plus4", pc_plus4, 32'h10);

        jump(32'h20, 0); check("jalr20", pc, 32'h20);
        br_taken = 1'b1; br_offset = -32'sd8;
        step(); idle();
        check("br_neg8", pc, 32'h18);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check("stall_hold", pc, 32'h18);
        end
        br_taken = 1'b1; br_offset = 32'h8;
        step(); idle();
        check("br_under_stall", pc, 32'h20);

        jump(32'h40, 0); check("jalr40", pc, 32'h40);
        jump(32'h1001, 0); check("jalr_bit0", pc, 32'h1000);
        check("jalr_bit0_mis", 32'(misalign), 32'h0);
        jump(32'h1002, 0); check("jalr_mis_pc", pc, 32'h100);
        check("jalr_mis_flag", 32'(misalign), 32'h1);
        step(); check("mis_clear_pc", pc, 32'h104);
        check("mis_clear", 32'(misalign), 32'h0);
        br_taken = 1'b1; br_offset = 32'h2;
        step(); idle();
        check("br_mis_pc", pc, 32'h100);
        check("br_mis_flag", 32'(misalign), 32'h1);

        jump(32'hFFFF_FFFC, 0);
        check("wrap_plus4", pc_plus4, 32'h0);
        step(); check("wrap_pc", pc, 32'h0);

        rst = 1'b1; step(); idle();
        jump(32'h10, 1); check("push1_ovf", 32'(ras_ovf), 32'h0);
        jump(32'h20, 1);
        jump(32'h30, 1);
        jump(32'h40, 1); check("push4_ovf", 32'(ras_ovf), 32'h0);
        jump(32'h80, 1); check("push5_ovf", 32'(ras_ovf), 32'h1);
        check("push5_pc", pc, 32'h80);
        ras_pop = 1'b1;
        step(); check("pop1", pc, 32'h44); check("ovf_clear", 32'(ras_ovf), 32'h0);
        step(); check("pop2", pc, 32'h34);
        step(); check("pop3", pc, 32'h24);
        check("pop3_empty", 32'(ras_empty), 32'h0);
        step(); check("pop4", pc, 32'h14);
        check("pop4_empty", 32'(ras_empty), 32'h1);
        step(); check("pop5_pc", pc, 32'h18);
        check("pop5_unf", 32'(ras_unf), 32'h1);
        idle();
        step(); check("after_unf_pc", pc, 32'h1C);
        check("unf_clear", 32'(ras_unf), 32'h0);

        jump(32'h80, 1); check("call80", pc, 32'h80);
        trap = 1'b1; ras_push = 1'b1; ras_pop = 1'b1;
        step(); idle();
        check("trap_pc", pc, 32'h100);
        flags("trap", 0, 0, 0, 0);
        ras_pop = 1'b1;
        step(); idle();
        check("trap_kept_top", pc, 32'h20);
        check("trap_kept_cnt", 32'(ras_empty), 32'h1);

        ras_push = 1'b1;
        step(); idle();
        check("seq_push_pc", pc, 32'h24);
        ras_push = 1'b1; ras_pop = 1'b1;
        step(); idle();
        check("swap_pc", pc, 32'h24);
        flags("swap", 0, 0, 0, 0);
        ras_pop = 1'b1;
        step(); idle();
        check("swap_top", pc, 32'h28);
        check("swap_empty", 32'(ras_empty), 32'h1);

        jump(32'h60, 1);
        rst = 1'b1; br_taken = 1'b1; br_offset = 32'h40; ras_push = 1'b1;
        step(); idle();
        check("midrst_pc", pc, 32'h0);
        flags("midrst", 0, 0, 0, 1);
        step(); check("post_rst_pc", pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch program-counter generator; the successor to the single-cycle PC register.
- Selects the next PC from these sources: sequential +4, PC-relative branch, absolute register jump (JALR), trap vector, and a hardware return-address stack (RAS).
- Detects misaligned targets and diverts them to the trap vector.
- Sits between the control/branch unit and instruction memory, and drives the fetch address every cycle.

Parameters:
- WIDTH, 32, address/data width in bits.
- DEPTH, 4, RAS entries; power of two, >=2.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC value loaded on trap or misalign; must be 4-byte aligned.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; suppresses only the sequential increment.
- br_taken  in  1  take PC-relative branch.
- br_offset  in  WIDTH  signed byte offset, added to the current pc.
- jalr_en  in  1  absolute register jump.
- jalr_target  in  WIDTH  raw JALR target; bit 0 is cleared internally.
- trap  in  1  exception/interrupt redirect.
- ras_push  in  1  call: push pc_plus4 onto the RAS.
- ras_pop  in  1  return: redirect to the RAS top and pop it.
- pc  out  WIDTH  current fetch PC (registered).
- pc_plus4  out  WIDTH  pc+4 (combinational).
- ras_empty  out  1  RAS count == 0.
- misalign  out  1  one-cycle pulse: the previous target had bits[1:0] != 0.
- ras_ovf  out  1  one-cycle pulse: push while full.
- ras_unf  out  1  one-cycle pulse: pop while empty.

Behaviour:
- Reset (rst=1 at a clk edge, overrides everything):
  - pc <= RESET_VEC.
  - RAS count, pointer and all entries <= 0.
  - misalign, ras_ovf, ras_unf <= 0; ras_empty = 1.
  - Reset mid-operation discards all in-flight redirects.
- Next-PC priority, highest first, evaluated every cycle:
  1. trap -> TRAP_VEC.
  2. ras_pop: RAS non-empty -> top entry; RAS empty -> pc+4, ras_unf=1.
  3. jalr_en -> jalr_target & ~1.
  4. br_taken -> pc + br_offset (two's complement, modulo 2^WIDTH; no -4 correction).
  5. stall -> pc unchanged.
  6. Otherwise -> pc+4.
- Redirects (items 1-4) take effect even when stall=1.
- All arithmetic is WIDTH bits and wraps modulo 2^WIDTH; pc+4 from 0xFFFF_FFFC yields 0.
- Misalign:
  - Checked only on a selected jalr or branch target.
  - If target[1:0] != 0: pc <= TRAP_VEC and misalign=1 for one cycle.
  - Latency: the target is presented in cycle N; pc shows TRAP_VEC and misalign is high in cycle N+1.
- Redirect latency: one cycle, with pc registered.
- RAS is a circular buffer with top pointer and count 0..DEPTH:
  - Push: stores pc_plus4 (the current pc+4); the pointer increments and count saturates at DEPTH.
  - Push when full: overwrites the oldest entry and ras_ovf=1 for one cycle.
  - Pop: reads the top entry; the pointer decrements and count decrements.
  - Pop when empty: the RAS is unchanged and ras_unf=1.
  - Simultaneous push and pop (co-routine return+call): the redirect uses the old top; the top entry is replaced by pc_plus4; count is unchanged; no ovf/unf.
  - Trap in the same cycle as push/pop: RAS operations are ignored.
  - stall does not gate RAS operations.
- Status outputs:
  - misalign, ras_ovf and ras_unf are registered and high for exactly one cycle per event.
  - ras_empty is combinational from count.

Test Plan:
- Reset then 3 free-running cycles -> pc = 0x0, 0x4, 0x8, 0xC; ras_empty=1.
- pc=0x20, br_taken with br_offset=-8 -> next pc=0x18; with stall=1 and no redirect -> pc held at 0x18 for the stall duration.
- pc=0x40, jalr_en with jalr_target=0x1001 -> pc=0x1000; jalr_target=0x1002 -> pc=TRAP_VEC (0x100) and a one-cycle misalign pulse.
- DEPTH=4: push at pc=0x0,0x10,0x20,0x30,0x40 -> ras_ovf pulses on the 5th push; 4 pops -> targets 0x44, 0x34, 0x24, 0x14, then ras_empty=1; a 5th pop -> pc=pc+4 and ras_unf=1.
- Simultaneous ras_push, ras_pop and trap at pc=0x80 -> pc=0x100; RAS contents and count unchanged.
- rst asserted while br_taken=1 and ras_push=1 -> pc=RESET_VEC, RAS empty, all pulses low on the following cycle.
